// File: rtl/tdes_sequencer_if.sv
// Handshake and data bundle between a Triple-DES requester, the sequencer
// and the single-pass DES stage it drives.
interface tdes_if;
  logic        start;
  logic        tdes_mode;
  logic [63:0] block_in;
  logic        next_data;
  logic [63:0] des_result;
  logic        data_ready;
  logic        rw_mode;
  logic [1:0]  key_select;
  logic [63:0] des_data_in;
  logic [63:0] block_out;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  pass_num;

  modport master (
    output start, tdes_mode, block_in, next_data, des_result,
    input  data_ready, rw_mode, key_select, des_data_in, block_out,
           busy, done, error, pass_num
  );

  modport slave (
    input  start, tdes_mode, block_in, next_data, des_result,
    output data_ready, rw_mode, key_select, des_data_in, block_out,
           busy, done, error, pass_num
  );
endinterface

// File: rtl/tdes_sequencer.sv
// Chains three DES passes into one Triple-DES operation.
// Encrypt: E(K1) D(K2) E(K3); decrypt: D(K3) E(K2) D(K1).
// Each pass result is written back into the working register, which is
// presented to the DES stage as its next input.
module tdes_sequencer #(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic  clk,
  input  logic  n_rst,
  tdes_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, FINISH, ERROR} state_t;

  state_t            state, state_nxt;
  logic [63:0]       work;
  logic [63:0]       out_q;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        pass;
  logic              mode;
  logic              done_q;
  logic              accept;
  logic              timed_out;
  logic              rw_dec;
  logic [1:0]        key_dec;

  assign accept    = bus.start && (state == IDLE || state == ERROR);
  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; completion takes priority over the timeout compare
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ERROR: if (accept) state_nxt = LAUNCH;
      LAUNCH:      state_nxt = WAIT;
      WAIT: begin
        if (bus.next_data)  state_nxt = (pass == 2'd2) ? FINISH : LAUNCH;
        else if (timed_out) state_nxt = ERROR;
      end
      FINISH:      state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Working register, pass index, timeout counter and result register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      work   <= '0;
      out_q  <= '0;
      cnt    <= '0;
      pass   <= '0;
      mode   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == FINISH);
      case (state)
        IDLE, ERROR: begin
          if (accept) begin
            work <= bus.block_in;
            mode <= bus.tdes_mode;
            pass <= '0;
            cnt  <= '0;
          end
        end
        LAUNCH: cnt <= '0;
        WAIT: begin
          if (bus.next_data) begin
            work <= bus.des_result;
            if (pass != 2'd2) pass <= pass + 2'd1;
          end else if (!timed_out) begin
            cnt <= cnt + 1'b1;
          end
        end
        FINISH:  out_q <= work;
        default: ;
      endcase
    end
  end

  // Per-pass direction and key; decrypt walks the key schedule backwards
  always_comb begin
    rw_dec  = 1'b0;
    key_dec = 2'd0;
    if (state == LAUNCH || state == WAIT) begin
      if (!mode) begin
        rw_dec  = pass[0];
        key_dec = pass;
      end else begin
        rw_dec  = ~pass[0];
        key_dec = 2'd2 - pass;
      end
    end
  end

  assign bus.data_ready  = (state == LAUNCH);
  assign bus.rw_mode     = rw_dec;
  assign bus.key_select  = key_dec;
  assign bus.des_data_in = work;
  assign bus.block_out   = out_q;
  assign bus.busy        = (state == LAUNCH) || (state == WAIT) || (state == FINISH);
  assign bus.done        = done_q;
  assign bus.error       = (state == ERROR);
  assign bus.pass_num    = pass;

endmodule
